// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op, state and handshake encodings for the iterative mul/div unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, either a right-shift-add multiply step
// or a left-shift restoring divide step on a 2*WIDTH+1 bit partial value.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH:0]   i_p,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH:0]   o_p
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [2*WIDTH:0] w_sh;
    logic             w_ge;

    // The upper W+1 bits never overflow: after each right shift the top bit is zero.
    always_comb begin
        w_sum  = i_p[2*WIDTH:WIDTH] + (i_p[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_sh   = {i_p[2*WIDTH-1:0], 1'b0};
        w_ge   = w_sh[2*WIDTH:WIDTH] >= {1'b0, i_b};
        w_diff = w_sh[2*WIDTH:WIDTH] - {1'b0, i_b};
        o_p    = !i_is_div ? {1'b0, w_sum, i_p[WIDTH-1:1]}
               : w_ge      ? {w_diff, w_sh[WIDTH-1:1], 1'b1}
               :             w_sh;
    end

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative signed/unsigned multiply and divide retiring STEP bits per cycle,
// operating on magnitudes with a final two's-complement sign correction.
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_is_div;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH:0]     r_p;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_accept;
    logic                 w_zero;
    logic                 w_sa;
    logic                 w_sb;
    logic                 w_last;
    logic [WIDTH-1:0]     w_ma;
    logic [WIDTH-1:0]     w_mb;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_final;
    logic [2*WIDTH:0]     w_chain [STEP+1];

    always_comb begin
        w_is_div    = (op_i == OP_DIVU) || (op_i == OP_DIV);
        w_is_signed = (op_i != OP_MULTU) && (op_i != OP_DIVU);
        w_accept    = (r_state == S_IDLE) && (start_i == DivStart) && !annul_i;
        w_zero      = w_is_div && (opdata2_i == '0);
        w_sa        = w_is_signed && opdata1_i[WIDTH-1];
        w_sb        = w_is_signed && opdata2_i[WIDTH-1];
        w_ma        = w_sa ? -opdata1_i : opdata1_i;
        w_mb        = w_sb ? -opdata2_i : opdata2_i;
        w_last      = (r_cnt == CW'(1));
        w_prod      = w_chain[STEP][2*WIDTH-1:0];
        w_q         = w_chain[STEP][WIDTH-1:0];
        w_r         = w_chain[STEP][2*WIDTH-1:WIDTH];
        w_final     = r_is_div ? {(r_neg_hi ? -w_r : w_r), (r_neg_lo ? -w_q : w_q)}
                    : (r_neg_lo ? -w_prod : w_prod);
    end

    assign w_chain[0] = r_p;

    for (genvar s = 0; s < STEP; s++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .i_is_div (r_is_div),
            .i_p      (w_chain[s]),
            .i_b      (r_b),
            .o_p      (w_chain[s+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Annul wins over completion; DONE waits for start to drop before re-arming.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_zero ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:   w_next = annul_i ? S_IDLE : (w_last ? S_DONE : S_RUN);
            S_DONE:  w_next = (annul_i || start_i == DivStop) ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (r_state == S_RUN);
        ready_o    = (r_state == S_DONE) ? DivResultReady : DivResultNotReady;
        div_zero_o = (r_state == S_DONE) && r_dz;
        result_o   = r_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_is_div <= w_is_div;
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= w_sa;
                r_dz     <= w_zero;
                r_b      <= w_mb;
                r_p      <= {{(WIDTH+1){1'b0}}, w_ma};
                r_cnt    <= CW'(N);
                if (w_zero) r_result <= {opdata1_i, {WIDTH{1'b1}}};
            end
            if (r_state == S_RUN) begin
                r_p   <= w_chain[STEP];
                r_cnt <= r_cnt - CW'(1);
                if (w_last && !annul_i) r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed vectors with a queue scoreboard on a STEP=1 and a STEP=4 instance.
module tb_iter_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        annul [2];
    logic [1:0]  op    [2];
    logic [31:0] d1    [2];
    logic [31:0] d2    [2];
    logic        busy  [2];
    logic        ready [2];
    logic        dz    [2];
    logic [63:0] res   [2];

    always #5 clk = ~clk;

    iter_muldiv #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start_i(start[0]), .op_i(op[0]), .opdata1_i(d1[0]),
        .opdata2_i(d2[0]), .annul_i(annul[0]), .busy_o(busy[0]), .ready_o(ready[0]),
        .result_o(res[0]), .div_zero_o(dz[0])
    );

    iter_muldiv #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .start_i(start[1]), .op_i(op[1]), .opdata1_i(d1[1]),
        .opdata2_i(d2[1]), .annul_i(annul[1]), .busy_o(busy[1]), .ready_o(ready[1]),
        .result_o(res[1]), .div_zero_o(dz[1])
    );

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            exp_t e;
            int   n = 0, t0 = 0, bcnt = 0;
            logic pready = 1'b0, pstart = 1'b0;
            forever begin
                @(negedge clk);
                n++;
                if (start[g] && !pstart) begin
                    t0   = n;
                    bcnt = 0;
                end
                if (busy[g]) bcnt++;
                if (ready[g] && !pready) begin
                    if ((g == 0 ? qa.size() : qb.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected ready: got ready=1, expected none", g);
                    end else begin
                        if (g == 0) e = qa.pop_front();
                        else        e = qb.pop_front();
                        check($sformatf("dut%0d result", g), res[g], e.res);
                        check($sformatf("dut%0d div_zero", g), 64'(dz[g]), 64'(e.dz));
                        check($sformatf("dut%0d latency", g), 64'(n - t0), 64'(e.lat));
                        check($sformatf("dut%0d busy cycles", g), 64'(bcnt), 64'(e.lat - 1));
                    end
                end
                pready = ready[g];
                pstart = start[g];
            end
        end
    end

    task automatic issue(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] er, input logic edz, input int elat);
        exp_t e;
        int   n;
        e.res = er;
        e.dz  = edz;
        e.lat = elat;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
        @(posedge clk); #1;
        op[d]    = o;
        d1[d]    = x;
        d2[d]    = y;
        start[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d ready timeout: got no ready in %0d cycles, expected %0d", d, n, elat);
        end
        start[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("dut%0d ready cleared", d), 64'(ready[d]), 64'd0);
        check($sformatf("dut%0d div_zero cleared", d), 64'(dz[d]), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            annul[i] = 1'b0;
            op[i]    = 2'b00;
            d1[i]    = '0;
            d2[i]    = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset ready", 64'(ready[0]), 64'd0);
        check("reset div_zero", 64'(dz[0]), 64'd0);
        check("reset result", res[0], 64'd0);
        rst = 1'b0;

        issue(0, 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33);
        issue(0, 2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33);
        issue(0, 2'b11, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0, 33);
        issue(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, 33);
        issue(0, 2'b01, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 33);
        issue(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33);
        issue(0, 2'b10, 32'h1234, 32'd0, {32'h00001234, 32'hFFFFFFFF}, 1'b1, 1);
        issue(0, 2'b11, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b1, 1);

        // annul partway through a divide; no result may appear
        @(posedge clk); #1;
        op[0] = 2'b10; d1[0] = 32'd500; d2[0] = 32'd3; start[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("busy before annul", 64'(busy[0]), 64'd1);
        annul[0] = 1'b1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        annul[0] = 1'b0;
        check("annul busy", 64'(busy[0]), 64'd0);
        check("annul ready", 64'(ready[0]), 64'd0);
        issue(0, 2'b10, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33);

        // asynchronous reset between edges in the middle of a multiply
        @(posedge clk); #1;
        op[0] = 2'b01; d1[0] = 32'd11; d2[0] = 32'd13; start[0] = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async reset busy", 64'(busy[0]), 64'd0);
        check("async reset ready", 64'(ready[0]), 64'd0);
        check("async reset result", res[0], 64'd0);
        start[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 2'b01, 32'd7, 32'd6, 64'd42, 1'b0, 33);
        issue(0, 2'b10, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 33);

        issue(1, 2'b01, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 9);
        issue(1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 9);
        issue(1, 2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 9);
        issue(1, 2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 9);

        repeat (5) @(posedge clk);
        check("dut0 results outstanding", 64'(qa.size()), 64'd0);
        check("dut1 results outstanding", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit, divide-only, 1-bit-per-cycle divider.
- Supports signed and unsigned MUL and DIV, a configurable radix (bits retired per cycle), annul, and a fixed divide-by-zero result.
- Uses the same start/ready handshake EX already drives: hold start high and stall while not ready, then drop start.
- Result is a 2*WIDTH {hi,lo} pair that EX writes to HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 8.
- STEP, 1, bits retired per RUN cycle (1, 2 or 4); must divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  request; sampled only in IDLE; held high by EX until ready_o is seen.
- op_i  in  2  {is_div, is_signed}: 00 multu, 01 mult, 10 divu, 11 div; sampled with start_i.
- opdata1_i  in  WIDTH  multiplicand or dividend; sampled with start_i.
- opdata2_i  in  WIDTH  multiplier or divisor; sampled with start_i.
- annul_i  in  1  abort current operation (flush).
- busy_o  out  1  high in RUN.
- ready_o  out  1  high in DONE; result_o valid.
- result_o  out  2*WIDTH  MUL: full product. DIV: {remainder, quotient}.
- div_zero_o  out  1  high in DONE when a DIV had divisor 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy_o, ready_o, div_zero_o = 0; result_o = 0; all internal registers cleared. Reset mid-RUN discards the operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0 → latch op_i and the operands.
  - Signed ops: store magnitudes of the operands plus the result sign flags. MUL sign = op1 sign XOR op2 sign. DIV quotient sign = op1 sign XOR op2 sign; remainder sign = op1 sign.
  - DIV with opdata2_i==0 → DONE next cycle.
  - Any other op → RUN, with iteration counter = WIDTH/STEP.
- RUN:
  - Each cycle retires STEP bits. MUL is shift-add. DIV is restoring shift-subtract on a 2*WIDTH+1 bit partial remainder.
  - Counter decrements each cycle. When it reaches 1, apply sign correction and register result_o → DONE.
- Latency: start sampled on edge 0; ready_o high after edge WIDTH/STEP+1 (33 cycles for 32/1, 9 cycles for 32/4). Divide-by-zero takes 1 cycle.
- DONE:
  - ready_o=1; result_o and div_zero_o stay stable.
  - start_i=0 → IDLE next cycle, with ready_o and div_zero_o cleared. result_o holds its last value.
  - start_i=1 → stay in DONE. No new op is accepted until start_i has been low for one cycle.
- annul_i=1 in RUN or DONE → IDLE next cycle, with ready_o=0 and busy_o=0. annul_i overrides start_i in IDLE. annul has priority over completion in the same cycle.
- Divide by zero: quotient = all ones; remainder = opdata1_i unmodified; div_zero_o=1.
- Signed overflow (DIV of min negative by -1): quotient = min negative, remainder = 0 (natural wrap of magnitude arithmetic). No flag.
- Sign correction is two's-complement negation over the full field width: 2*WIDTH for the product, WIDTH for quotient and remainder.
- No early termination; latency is data-independent except divide by zero.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding constants (OP_MULTU/OP_MULT/OP_DIVU/OP_DIV),
  - state encoding,
  - the DivStart/DivStop and DivResultReady/NotReady constants already used by EX.
- One sub-module, muldiv_step: combinational single-bit MUL/DIV iteration, instantiated STEP times in a chain inside the top.

Test Plan:
- divu 100 / 7, WIDTH=32, STEP=1, start held → ready_o rises after 33 cycles; result_o={32'd2, 32'd14}; busy_o high for 32 cycles.
- div -7 / 2 → result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; div 32'h80000000 / 32'hFFFFFFFF → {32'h0, 32'h80000000}.
- mult -3 * 5 → 64'hFFFFFFFF_FFFFFFF1; multu 32'hFFFFFFFF * 32'hFFFFFFFF → 64'hFFFFFFFE_00000001. Repeat both with STEP=4: same results, ready after 9 cycles.
- divu 32'h1234 / 0 → ready_o one cycle after start; result_o={32'h1234, 32'hFFFFFFFF}; div_zero_o=1; dropping start → IDLE, flags clear.
- annul_i pulsed at RUN cycle 10 → IDLE next cycle, ready_o never rises. Then an immediate new divu 9/3 → {0, 3} with full latency.
- Assert rst asynchronously mid-RUN (between clock edges) → outputs zero immediately. After release, a back-to-back mult, then divu, with start dropped one cycle between them → both correct, with no stale ready_o.
